// File: rtl/issue_buffer_pkg.sv
// Issue buffer package: geometry constants and the fetch-valid decode helper.
`include "issue_buffer_defines.sv"

package issue_buffer_pkg;

  localparam int IB_DEPTH    = `ISSUE_BUF_DEPTH;
  localparam int IB_PTR_BITS = $clog2(IB_DEPTH);

  // Pair-granular fetch: 2'b10 has no younger-only meaning and writes nothing.
  function automatic logic [1:0] push_count(input logic [1:0] fetch_valid);
    logic [1:0] n;
    case (fetch_valid)
      2'b11:   n = 2'd2;
      2'b01:   n = 2'd1;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/issue_buffer_defines.sv
// Shared core-wide defines: instruction width, the NOP encoding and the issue buffer depth.
// Guarded so every file can include it and it can also be compiled standalone.
`ifndef ISSUE_BUFFER_DEFINES_SV
`define ISSUE_BUFFER_DEFINES_SV

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif

`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0013
`endif

`ifndef ISSUE_BUF_DEPTH
`define ISSUE_BUF_DEPTH 8
`endif

`endif

// File: rtl/issue_buffer_ram.sv
// DEPTH x INST_WIDTH register array with two write ports and two asynchronous read ports.
// Contents are intentionally not reset; validity is tracked by the pointers in the parent.
`include "issue_buffer_defines.sv"

module issue_buffer_ram #(
  parameter int DEPTH      = 8,
  parameter int PTR_BITS   = 3,
  parameter int INST_WIDTH = `INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  we0,
  input  logic [PTR_BITS-1:0]   waddr0,
  input  logic [INST_WIDTH-1:0] wdata0,
  input  logic                  we1,
  input  logic [PTR_BITS-1:0]   waddr1,
  input  logic [INST_WIDTH-1:0] wdata1,
  input  logic [PTR_BITS-1:0]   raddr0,
  output logic [INST_WIDTH-1:0] rdata0,
  input  logic [PTR_BITS-1:0]   raddr1,
  output logic [INST_WIDTH-1:0] rdata1
);

  logic [INST_WIDTH-1:0] mem_r [DEPTH];

  // Storage write; the parent never drives both ports to the same address.
  always_ff @(posedge clk) begin
    if (we0) mem_r[waddr0] <= wdata0;
    if (we1) mem_r[waddr1] <= wdata1;
  end

  assign rdata0 = mem_r[raddr0];
  assign rdata1 = mem_r[raddr1];

endmodule

// File: rtl/issue_buffer.sv
// Dual-wide instruction FIFO between fetch and steering: pushes 0-2 per cycle and
// presents the two oldest entries, holding a split pair for one extra cycle.
`include "issue_buffer_defines.sv"

module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int DEPTH      = IB_DEPTH,
  parameter int PTR_BITS   = IB_PTR_BITS,
  parameter int INST_WIDTH = `INST_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            fetch_valid,
  input  logic [INST_WIDTH-1:0] fetch_inst0,
  input  logic [INST_WIDTH-1:0] fetch_inst1,
  output logic                  fetch_ready,
  input  logic                  flush,
  input  logic                  stall,
  input  logic                  steer_stall,
  output logic [INST_WIDTH-1:0] instruction0_out,
  output logic [INST_WIDTH-1:0] instruction1_out,
  output logic [1:0]            issue_valid,
  output logic [PTR_BITS:0]     count
);

  localparam logic [PTR_BITS:0]     READY_MAX = (PTR_BITS+1)'(DEPTH - 2);
  localparam logic [PTR_BITS:0]     CNT_ZERO  = (PTR_BITS+1)'(0);
  localparam logic [PTR_BITS:0]     CNT_TWO   = (PTR_BITS+1)'(2);
  localparam logic [PTR_BITS-1:0]   PTR_ONE   = PTR_BITS'(1);
  localparam logic [INST_WIDTH-1:0] NOP       = INST_WIDTH'(`NOP_INSTRUCTION);

  logic [PTR_BITS-1:0]   head_r, tail_r;
  logic [PTR_BITS:0]     cnt_r, cnt_next_s;
  logic [1:0]            push_n_s, pop_n_s, issue_valid_s;
  logic                  fetch_ready_s;
  logic [INST_WIDTH-1:0] rdata0_s, rdata1_s;

  assign fetch_ready_s = (cnt_r <= READY_MAX);

  // Push/pop decode; flush masks both the presented pair and any write.
  always_comb begin
    push_n_s      = 2'd0;
    pop_n_s       = 2'd0;
    issue_valid_s = 2'b00;
    if (flush) begin
      issue_valid_s = 2'b00;
    end else begin
      issue_valid_s = {(cnt_r >= CNT_TWO), (cnt_r != CNT_ZERO)};
    end
    if (fetch_ready_s && !flush) begin
      push_n_s = push_count(fetch_valid);
    end else begin
      push_n_s = 2'd0;
    end
    if (stall || steer_stall) begin
      pop_n_s = 2'd0;
    end else begin
      pop_n_s = {1'b0, issue_valid_s[0]} + {1'b0, issue_valid_s[1]};
    end
    cnt_next_s = cnt_r + (PTR_BITS+1)'(push_n_s) - (PTR_BITS+1)'(pop_n_s);
  end

  // Pointer and occupancy state; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= '0;
    end else if (flush) begin
      head_r <= '0;
      tail_r <= '0;
      cnt_r  <= '0;
    end else begin
      head_r <= head_r + PTR_BITS'(pop_n_s);
      tail_r <= tail_r + PTR_BITS'(push_n_s);
      cnt_r  <= cnt_next_s;
    end
  end

  issue_buffer_ram #(
    .DEPTH      (DEPTH),
    .PTR_BITS   (PTR_BITS),
    .INST_WIDTH (INST_WIDTH)
  ) u_ram (
    .clk    (clk),
    .we0    (push_n_s != 2'd0),
    .waddr0 (tail_r),
    .wdata0 (fetch_inst0),
    .we1    (push_n_s == 2'd2),
    .waddr1 (tail_r + PTR_ONE),
    .wdata1 (fetch_inst1),
    .raddr0 (head_r),
    .rdata0 (rdata0_s),
    .raddr1 (head_r + PTR_ONE),
    .rdata1 (rdata1_s)
  );

  assign fetch_ready      = fetch_ready_s;
  assign issue_valid      = issue_valid_s;
  assign count            = cnt_r;
  assign instruction0_out = issue_valid_s[0] ? rdata0_s : NOP;
  assign instruction1_out = issue_valid_s[1] ? rdata1_s : NOP;

endmodule

// File: tb/tb_issue_buffer.sv
// Directed bench for issue_buffer: stimulus pushes the expected presented pair into a
// scoreboard queue; a negedge monitor pops and compares whenever issue_valid is non-zero.
`include "issue_buffer_defines.sv"

module tb_issue_buffer;

  localparam int W = `INST_WIDTH;
  localparam logic [W-1:0] NOP = W'(`NOP_INSTRUCTION);

  typedef struct packed {
    logic [1:0]   v;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   fetch_valid = 2'b00;
  logic [W-1:0] fetch_inst0 = '0;
  logic [W-1:0] fetch_inst1 = '0;
  logic         fetch_ready;
  logic         flush = 1'b0;
  logic         stall = 1'b0;
  logic         steer_stall = 1'b0;
  logic [W-1:0] instruction0_out, instruction1_out;
  logic [1:0]   issue_valid;
  logic [3:0]   count;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  issue_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_valid      (fetch_valid),
    .fetch_inst0      (fetch_inst0),
    .fetch_inst1      (fetch_inst1),
    .fetch_ready      (fetch_ready),
    .flush            (flush),
    .stall            (stall),
    .steer_stall      (steer_stall),
    .instruction0_out (instruction0_out),
    .instruction1_out (instruction1_out),
    .issue_valid      (issue_valid),
    .count            (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented pair must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && issue_valid != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected: got v=%b %h %h, scoreboard empty",
                 issue_valid, instruction0_out, instruction1_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (issue_valid !== e.v || instruction0_out !== e.i0 || instruction1_out !== e.i1) begin
          errors++;
          $display("FAIL issue_pair: got v=%b %h %h expected v=%b %h %h",
                   issue_valid, instruction0_out, instruction1_out, e.v, e.i0, e.i1);
        end
      end
    end
  end

  // One cycle: drive inputs, state the expected presentation/count/ready, advance one edge.
  task automatic cyc(input logic [1:0] fv, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic st, input logic sst, input logic fl,
                     input logic [1:0] ev, input logic [W-1:0] e0, input logic [W-1:0] e1,
                     input int ecnt, input logic erdy);
    fetch_valid = fv;
    fetch_inst0 = a;
    fetch_inst1 = b;
    stall       = st;
    steer_stall = sst;
    flush       = fl;
    if (fv == 2'b10) $display("note: illegal fetch_valid=10 driven, expecting no write");
    if (ev != 2'b00) exp_q.push_back('{v: ev, i0: e0, i1: e1});
    #1;
    chk("count", 64'(count), 64'(ecnt));
    chk("fetch_ready", 64'(fetch_ready), 64'(erdy));
    if (ev == 2'b00) begin
      chk("idle_valid", 64'(issue_valid), 64'(2'b00));
      chk("idle_nop0", 64'(instruction0_out), 64'(NOP));
      chk("idle_nop1", 64'(instruction1_out), 64'(NOP));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Outputs while held in reset.
    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_ready", 64'(fetch_ready), 64'd1);
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_nop0", 64'(instruction0_out), 64'(NOP));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic pair push then pop.
    cyc(2'b11, 'hA1, 'hA2, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b11, 'hA1, 'hA2, 2, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);

    // Illegal 10 writes nothing.
    cyc(2'b10, 'hEE, 'hEF, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);

    // Steering split: pair held one extra cycle, then consumed; counts 3,3,1,0.
    cyc(2'b11, 'hB1, 'hB2, 1, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b01, 'hB3, 'h0, 1, 0, 0, 2'b11, 'hB1, 'hB2, 2, 1);
    cyc(2'b00, 'h0, 'h0, 0, 1, 0, 2'b11, 'hB1, 'hB2, 3, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b11, 'hB1, 'hB2, 3, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b01, 'hB3, NOP, 1, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);

    // Fill to full under stall (head=5); a push at count 8 is refused.
    cyc(2'b11, 'hC0, 'hC1, 1, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b11, 'hC2, 'hC3, 1, 0, 0, 2'b11, 'hC0, 'hC1, 2, 1);
    cyc(2'b11, 'hC4, 'hC5, 1, 0, 0, 2'b11, 'hC0, 'hC1, 4, 1);
    cyc(2'b11, 'hC6, 'hC7, 1, 0, 0, 2'b11, 'hC0, 'hC1, 6, 1);
    cyc(2'b11, 'hD0, 'hD1, 1, 0, 0, 2'b11, 'hC0, 'hC1, 8, 0);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b11, 'hC0, 'hC1, 8, 0);
    // Count 7 also refuses a pair; head=7 straddles the wrap (entries 7 and 0).
    cyc(2'b01, 'hC8, 'h0, 1, 0, 0, 2'b11, 'hC2, 'hC3, 6, 1);
    cyc(2'b11, 'hD2, 'hD3, 1, 0, 0, 2'b11, 'hC2, 'hC3, 7, 0);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b11, 'hC2, 'hC3, 7, 0);
    // Head now 1.
    cyc(2'b00, 'h0, 'h0, 1, 0, 0, 2'b11, 'hC4, 'hC5, 5, 1);
    // Simultaneous push of one and pop of two: 5 -> 4.
    cyc(2'b01, 'hE0, 'h0, 0, 0, 0, 2'b11, 'hC4, 'hC5, 5, 1);

    // Flush with a push and a pop pending at count 4.
    cyc(2'b11, 'hF0, 'hF1, 0, 0, 1, 2'b00, NOP, NOP, 4, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);

    // Build count 5, then async reset mid-burst.
    cyc(2'b11, 'h60, 'h61, 1, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b11, 'h62, 'h63, 1, 0, 0, 2'b11, 'h60, 'h61, 2, 1);
    cyc(2'b01, 'h64, 'h0, 1, 0, 0, 2'b11, 'h60, 'h61, 4, 1);
    fetch_valid = 2'b11;
    fetch_inst0 = 'h70;
    fetch_inst1 = 'h71;
    stall = 1'b1;
    chk("pre_rst_count", 64'(count), 64'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_ready", 64'(fetch_ready), 64'd1);
    chk("async_rst_valid", 64'(issue_valid), 64'd0);
    chk("async_rst_nop0", 64'(instruction0_out), 64'(NOP));
    chk("async_rst_nop1", 64'(instruction1_out), 64'(NOP));
    fetch_valid = 2'b00;
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("held_rst_count", 64'(count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Normal operation after reset.
    cyc(2'b11, 'h81, 'h82, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b11, 'h81, 'h82, 2, 1);
    cyc(2'b00, 'h0, 'h0, 0, 0, 0, 2'b00, NOP, NOP, 0, 1);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
